// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Holds the FSM state encoding and instruction field positions.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_INSTR_W     = 12;
    localparam int DEF_STACK_DEPTH = 8;

    // Opcode is the top nibble of the instruction word.
    localparam int OP_W     = 4;
    localparam int OP_MSB_OFS = 1;
    localparam int OP_LSB_OFS = OP_W;

endpackage

// File: rtl/return_stack.sv
// Hardware return stack: pointer is reset, storage is not.
// Push writes at sp, pop exposes the entry at sp-1 as top.
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PC_W-1:0]                push_data,
    output logic [PC_W-1:0]                top,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           full,
    output logic                           empty
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int SW = AW + 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign wr_idx = sp[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign top    = mem[rd_idx];
    assign full   = (sp == SW'(STACK_DEPTH));
    assign empty  = (sp == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SW'(1);
        end else if (pop) begin
            sp <= sp - SW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch over req/ack, one-cycle execute strobe,
// next-PC selection from decoder controls with a hardware return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    output logic                          imem_req,
    output logic [PC_W-1:0]               imem_addr,
    input  logic                          imem_ack,
    input  logic [INSTR_W-1:0]            imem_rdata,
    output logic [INSTR_W-1:0]            instr,
    output logic                          exec_en,
    input  logic                          stack_up,
    input  logic                          stack_down,
    input  logic                          c_cond,
    input  logic                          c_stack,
    input  logic                          cond_met,
    output logic [PC_W-1:0]               pc,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic                          stack_err,
    output logic                          halted
);

    state_t          state;
    state_t          state_nx;
    logic            in_exec;
    logic            push;
    logic            pop;
    logic            err;
    logic            full;
    logic            empty;
    logic [PC_W-1:0] top;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nx;

    assign in_exec   = (state == EXEC);
    assign target    = instr[PC_W-1:0];
    assign pc_inc    = pc + PC_W'(1);
    assign imem_addr = pc;

    return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

    // Call outranks return, return outranks jump; errors freeze the pc.
    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        err   = 1'b0;
        pc_nx = pc_inc;
        if (stack_up) begin
            if (full) begin
                err   = in_exec;
                pc_nx = pc;
            end else begin
                push  = in_exec;
                pc_nx = target;
            end
        end else if (stack_down) begin
            if (empty) begin
                err   = in_exec;
                pc_nx = pc;
            end else begin
                pop   = in_exec;
                pc_nx = top;
            end
        end else if (c_cond && !c_stack && cond_met) begin
            pc_nx = target;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (run) state_nx = FETCH;
            FETCH: if (imem_ack) state_nx = EXEC;
            EXEC: begin
                if (err)      state_nx = HALT;
                else if (run) state_nx = FETCH;
                else          state_nx = IDLE;
            end
            HALT:  state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        exec_en = (state == EXEC);
        halted  = (state == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            instr     <= '0;
            pc        <= '0;
            stack_err <= 1'b0;
        end else begin
            state    <= state_nx;
            imem_req <= (state_nx == FETCH);
            if (state == FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (in_exec) begin
                pc <= pc_nx;
            end
            if (err) begin
                stack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed programs, a memory responder
// and a monitor that checks pc/sp/instr at every execute strobe.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [11:0] imem_rdata;
    logic [11:0] instr;
    logic        exec_en;
    logic        stack_up;
    logic        stack_down;
    logic        c_cond;
    logic        c_stack;
    logic        cond_met;
    logic [7:0]  pc;
    logic [3:0]  sp;
    logic        stack_err;
    logic        halted;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .exec_en    (exec_en),
        .stack_up   (stack_up),
        .stack_down (stack_down),
        .c_cond     (c_cond),
        .c_stack    (c_stack),
        .cond_met   (cond_met),
        .pc         (pc),
        .sp         (sp),
        .stack_err  (stack_err),
        .halted     (halted)
    );

    typedef struct packed {
        logic [7:0]  pc;
        logic [3:0]  sp;
        logic [11:0] ins;
    } exp_t;

    exp_t        sbq[$];
    logic [11:0] imem [256];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_lat = 1;
    int          wait_cnt = 0;
    logic        stray_ack = 1'b0;
    int          cyc = 0;
    int          last_exec = 0;
    int          last_gap = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference decoder: 1110 call, 1100 return, 1000 jump, 0xxx ALU.
    always_comb begin
        stack_up   = (instr[11:8] == 4'b1110);
        stack_down = (instr[11:8] == 4'b1100);
        c_cond     = instr[11];
        c_stack    = (instr[11:8] == 4'b1100);
    end

    always @(negedge clk) begin
        if (imem_req) begin
            imem_ack   = (wait_cnt >= ack_lat);
            imem_rdata = imem[imem_addr];
            wait_cnt++;
        end else begin
            imem_ack   = stray_ack;
            imem_rdata = 12'hFFF;
            wait_cnt   = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exec_en) begin
            n_cmp++;
            last_gap  = cyc - last_exec;
            last_exec = cyc;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_exec pc=%h sp=%0d instr=%h",
                         pc, sp, instr);
            end else begin
                e = sbq.pop_front();
                if ({pc, sp, instr} !== e) begin
                    n_err++;
                    $display("FAIL sb_exec got pc=%h sp=%0d ins=%h exp pc=%h sp=%0d ins=%h",
                             pc, sp, instr, e.pc, e.sp, e.ins);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic expect_exec(input logic [7:0] p, input logic [3:0] s);
        exp_t e;
        e.pc  = p;
        e.sp  = s;
        e.ins = imem[p];
        sbq.push_back(e);
    endtask

    task automatic fill(input logic [11:0] v);
        for (int i = 0; i < 256; i++) imem[i] = v;
    endtask

    task automatic do_reset();
        run      = 1'b0;
        rst_n    = 1'b0;
        ack_lat  = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_n(input int n);
        int cnt = 0;
        bit done = 0;
        run = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (exec_en) cnt++;
            if (cnt == n) begin
                run  = 1'b0;
                done = 1;
            end
        end
        chk("run_n_timeout", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic sb_drained(input string name);
        chk(name, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        int nreq;
        cond_met = 1'b0;
        rst_n    = 1'b0;
        run      = 1'b0;
        #1;
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_state",
            {pc, sp, instr, exec_en, stack_err, halted}, 32'd0);

        // Sequential fetch, conditional jump to 0xFE, wrap FF -> 0.
        do_reset();
        fill(12'h0AB);
        imem[4]    = 12'h8FE;
        imem[8'hFE] = 12'h123;
        cond_met   = 1'b1;
        for (int i = 0; i < 5; i++) expect_exec(8'(i), 4'd0);
        expect_exec(8'hFE, 4'd0);
        expect_exec(8'hFF, 4'd0);
        expect_exec(8'h00, 4'd0);
        run_n(8);
        sb_drained("seq_drained");
        chk("exec_gap", 32'(last_gap), 32'd3);
        chk("seq_idle_pc", {imem_req, pc}, 32'h001);

        // Jump not taken at pc 5.
        do_reset();
        fill(12'h0AB);
        imem[5]  = 12'h840;
        cond_met = 1'b0;
        for (int i = 0; i < 7; i++) expect_exec(8'(i), 4'd0);
        run_n(7);
        sb_drained("jmp_nt_drained");
        chk("jmp_nt_pc", 32'(pc), 32'h07);

        // Jump taken at pc 5.
        do_reset();
        cond_met = 1'b1;
        for (int i = 0; i < 6; i++) expect_exec(8'(i), 4'd0);
        expect_exec(8'h40, 4'd0);
        run_n(7);
        sb_drained("jmp_t_drained");
        chk("jmp_t_pc", 32'(pc), 32'h41);

        // Call 0x20 from 0x10, then return to 0x11.
        do_reset();
        fill(12'h0AB);
        imem[0]     = 12'h810;
        imem[8'h10] = 12'hE20;
        imem[8'h20] = 12'hC00;
        expect_exec(8'h00, 4'd0);
        expect_exec(8'h10, 4'd0);
        expect_exec(8'h20, 4'd1);
        expect_exec(8'h11, 4'd0);
        run_n(4);
        sb_drained("call_ret_drained");
        chk("call_ret_pc_sp", {pc, sp}, {20'd0, 8'h12, 4'd0});

        // Eight nested calls fill the stack; the ninth overflows.
        do_reset();
        fill(12'h0AB);
        for (int i = 0; i < 9; i++) begin
            imem[i] = 12'hE00 | 12'(i + 1);
            expect_exec(8'(i), 4'(i));
        end
        run_n(9);
        sb_drained("ovf_drained");
        chk("ovf_flags", {stack_err, halted, exec_en}, 32'b110);
        chk("ovf_pc_sp", {pc, sp}, {20'd0, 8'h08, 4'd8});
        nreq = 0;
        run  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (imem_req || exec_en) nreq++;
        end
        run = 1'b0;
        chk("halt_no_req", 32'(nreq), 32'd0);

        // Return with an empty stack.
        do_reset();
        fill(12'h0AB);
        imem[0] = 12'hC00;
        expect_exec(8'h00, 4'd0);
        run_n(1);
        sb_drained("unf_drained");
        chk("unf_state", {pc, sp, stack_err, halted}, {18'd0, 8'h00, 4'd0, 2'b11});

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        fill(12'h0AB);
        expect_exec(8'h00, 4'd0);
        expect_exec(8'h01, 4'd0);
        ack_lat = 5;
        run     = 1'b1;
        nreq    = 0;
        for (int c = 0; c < 100 && nreq < 2; c++) begin
            @(negedge clk);
            if (exec_en) nreq++;
        end
        @(negedge clk);
        chk("midfetch_req", {imem_req, pc}, {23'd0, 1'b1, 8'h02});
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req), 32'd0);
        chk("async_outputs",
            {pc, sp, instr, exec_en, stack_err, halted}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_drained("midfetch_drained");

        // Acks that arrive outside FETCH are ignored.
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        chk("stray_ack", {instr, exec_en, imem_req}, 32'd0);

        // Dropping run during FETCH keeps the request up until ack.
        do_reset();
        ack_lat = 3;
        expect_exec(8'h00, 4'd0);
        run = 1'b1;
        nreq = 0;
        for (int c = 0; c < 50 && !imem_req; c++) @(negedge clk);
        run  = 1'b0;
        nreq = 1;
        for (int c = 0; c < 50 && !exec_en; c++) begin
            @(negedge clk);
            if (imem_req) nreq++;
        end
        chk("req_held", 32'(nreq), 32'd4);
        nreq = 0;
        repeat (5) begin
            @(negedge clk);
            if (imem_req) nreq++;
        end
        chk("idle_no_req", {24'(nreq), pc}, {24'd0, 8'h01});
        expect_exec(8'h01, 4'd0);
        run_n(1);
        sb_drained("rerun_drained");
        chk("rerun_pc", 32'(pc), 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing controller for the 4-bit-opcode micro-processor.
- Owns the program counter and a hardware return stack.
- Fetches each instruction over a req/ack handshake, then issues a one-cycle execute strobe.
- Picks the next PC from the opcode decoder's control outputs: stack_up (call), stack_down (return), c_cond (jump), c_stack (stack target select).

Parameters:
- PC_W, 8: program counter / instruction address width.
- INSTR_W, 12: instruction width; opcode = instr[INSTR_W-1:INSTR_W-4], jump/call target = instr[PC_W-1:0].
- STACK_DEPTH, 8: return-stack entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- run  in  1  permits starting a new fetch.
- imem_req  out  1  fetch request (registered).
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  INSTR_W  fetched instruction.
- instr  out  INSTR_W  latched current instruction; feeds the external decoder.
- exec_en  out  1  one-cycle execute strobe; external logic gates reg_write/mem_write with it.
- stack_up  in  1  decoder: call.
- stack_down  in  1  decoder: return.
- c_cond  in  1  decoder: jump class.
- c_stack  in  1  decoder: target from stack.
- cond_met  in  1  ALU flag condition for conditional jump.
- pc  out  PC_W  program counter.
- sp  out  $clog2(STACK_DEPTH)+1  stack occupancy.
- stack_err  out  1  sticky over/underflow flag.
- halted  out  1  controller in HALT.

Behaviour:
- Reset (async, rst_n=0): pc=0, sp=0, instr=0, imem_req=0, exec_en=0, stack_err=0, halted=0, state=IDLE. Asserting reset mid-fetch drops imem_req immediately; a late ack is ignored.
- States:
  - IDLE: run=1 -> FETCH, imem_req<=1.
  - FETCH: imem_req held 1 until imem_ack, regardless of run. On imem_ack: instr<=imem_rdata, imem_req<=0 -> EXEC.
  - EXEC: exec_en=1 for exactly this cycle; decoder inputs are valid (combinational from instr). Next-PC update happens at the end of EXEC; then -> FETCH (imem_req<=1) if run else IDLE.
  - HALT: halted=1, exec_en=0, imem_req=0; exits only by reset.
- imem_ack outside FETCH: ignored.
- Minimum throughput: 2 cycles/instruction (ack in the first FETCH cycle).
- Next-PC priority in EXEC:
  1. stack_up (call): not full -> stack[sp]<=pc+1 (mod 2^PC_W), sp<=sp+1, pc<=target. Unconditional; cond_met ignored. Full (sp==STACK_DEPTH) -> no push, pc unchanged, stack_err<=1 -> HALT.
  2. stack_down (return): not empty -> pc<=stack[sp-1], sp<=sp-1. Empty (sp==0) -> pc unchanged, stack_err<=1 -> HALT.
  3. c_cond & !c_stack & cond_met: pc<=target.
  4. Otherwise: pc<=pc+1, wrapping 2^PC_W-1 -> 0.
- Errored instruction still asserts exec_en for its EXEC cycle; the error takes effect afterwards.
- Stack contents are not reset; only sp is. Popped entries are not cleared.
- Call at pc=2^PC_W-1 pushes 0.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum {IDLE, FETCH, EXEC, HALT};
  - opcode field position constants;
  - default parameter constants.
- Sub-module return_stack (PC_W, STACK_DEPTH):
  - inputs: push, pop, push_data;
  - outputs: top, sp, full, empty;
  - push and pop are mutually exclusive, guaranteed by the priority above.

Test Plan:
- Reset, run=1, ack one cycle after each req, plain ALU opcodes -> imem_addr 0,1,2,3; exec_en pulses once per 3 cycles; pc wraps 255 -> 0.
- Jump opcode 1000 with cond_met=0 at pc=5 -> pc=6. Same with cond_met=1 and target 0x40 -> pc=0x40.
- Call (1110, target 0x20) at pc=0x10, then return (1100) -> sp 0->1->0; pc 0x20, then 0x11.
- 8 nested calls followed by a 9th -> 9th sets stack_err=1, halted=1, pc holds; no further imem_req.
- Return with sp=0 -> stack_err=1, HALT. Deassert rst_n mid-FETCH -> imem_req=0 asynchronously; all outputs at reset values.
- run=0 during FETCH before ack -> imem_req stays 1 until ack; after EXEC -> IDLE, no new req until run=1.
